// File: rtl/uart_rx_packer.sv
// Packs UART receive bytes MSB-first into 32-bit words and queues them in a
// first-word-fall-through FIFO; partial words leave on idle timeout or flush.
module uart_rx_packer #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 100000
) (
   input  logic                     sys_clk,
   input  logic                     sys_nrst,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     flush,
   output logic                     word_valid,
   output logic [31:0]              word_data,
   output logic [2:0]               word_bytes,
   input  logic                     word_ready,
   output logic                     overflow,
   input  logic                     clr_ovf,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW     = $clog2(DEPTH);
   localparam int LW     = PW + 1;
   localparam int TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TMO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   sr_q, sr_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [34:0]   mem [DEPTH];

   logic [31:0]   ins, merged;
   logic [2:0]    fill;
   logic          tmo_fire, push, pop, wr_en, drop;
   logic [34:0]   head;

   // Byte k lands in bits [31-8k:24-8k]; earlier bytes are already in sr_q.
   always_comb begin
      ins = '0;
      case (cnt_q)
         2'd0: ins[31:24] = rx_data;
         2'd1: ins[23:16] = rx_data;
         2'd2: ins[15:8]  = rx_data;
         default: ins[7:0] = rx_data;
      endcase
      merged = rx_valid ? (sr_q | ins) : sr_q;
      fill   = {1'b0, cnt_q} + {2'b00, rx_valid};
   end

   // The timer counts the idle cycle in progress, so it fires one short of TIMEOUT.
   assign tmo_fire = (TIMEOUT != 0) && !rx_valid && (cnt_q != 2'd0) &&
                     (tmr_q == TW'(TMO_M1));
   assign push     = (rx_valid && cnt_q == 2'd3) || (flush && fill != 3'd0) || tmo_fire;
   assign pop      = word_valid && word_ready;
   assign wr_en    = push && ((level_q != FULL) || pop);
   assign drop     = push && (level_q == FULL) && !pop;

   always_comb begin
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      tmr_d    = tmr_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) begin
         cnt_d = 2'd0;
         sr_d  = '0;
         tmr_d = '0;
      end else begin
         cnt_d = fill[1:0];
         sr_d  = merged;
         if (rx_valid || cnt_q == 2'd0) tmr_d = '0;
         else                           tmr_d = tmr_q + TW'(1);
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en && !pop)      level_d = level_q + LW'(1);
      else if (!wr_en && pop) level_d = level_q - LW'(1);
      if (drop)         ovf_d = 1'b1;
      else if (clr_ovf) ovf_d = 1'b0;
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         cnt_q    <= '0;
         sr_q     <= '0;
         tmr_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         tmr_q    <= tmr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[wr_ptr_q] <= {fill, merged};
   end

   assign head       = mem[rd_ptr_q];
   assign word_valid = (level_q != '0);
   assign word_data  = word_valid ? head[31:0]  : '0;
   assign word_bytes = word_valid ? head[34:32] : '0;
   assign overflow   = ovf_q;
   assign level      = level_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized and directed bench for uart_rx_packer against a byte-queue reference model.
module tb_uart_rx_packer;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 50;

   logic        sys_clk = 1'b0;
   logic        sys_nrst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        flush = 1'b0;
   logic        word_valid;
   logic [31:0] word_data;
   logic [2:0]  word_bytes;
   logic        word_ready = 1'b0;
   logic        overflow;
   logic        clr_ovf = 1'b0;
   logic [4:0]  level;

   int checks = 0;
   int errors = 0;

   // Reference model: bytes of the word being built, idle cycle count, FIFO of {bytes,data}.
   logic [7:0]  m_bytes[$];
   int          m_idle = 0;
   logic [34:0] m_fifo[$];
   logic        m_ovf = 1'b0;

   uart_rx_packer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk(sys_clk), .sys_nrst(sys_nrst), .rx_valid(rx_valid), .rx_data(rx_data),
      .flush(flush), .word_valid(word_valid), .word_data(word_data),
      .word_bytes(word_bytes), .word_ready(word_ready), .overflow(overflow),
      .clr_ovf(clr_ovf), .level(level)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [34:0] pack_word();
      logic [31:0] d;
      d = '0;
      for (int i = 0; i < m_bytes.size(); i++) d[31-8*i -: 8] = m_bytes[i];
      return {3'(m_bytes.size()), d};
   endfunction

   task automatic model_reset();
      m_bytes.delete();
      m_fifo.delete();
      m_idle = 0;
      m_ovf  = 1'b0;
   endtask

   // Applies the current inputs to the model as one clock edge.
   task automatic model_edge();
      logic        do_pop, do_push;
      logic [34:0] w;
      int          sz;
      sz      = m_fifo.size();
      do_pop  = (sz > 0) && word_ready;
      do_push = 1'b0;
      w       = '0;
      if (rx_valid) begin
         m_bytes.push_back(rx_data);
         m_idle = 0;
      end else if (m_bytes.size() > 0) begin
         m_idle++;
      end
      if (m_bytes.size() == 4 || (flush && m_bytes.size() > 0) ||
          (!rx_valid && m_bytes.size() > 0 && m_idle == TIMEOUT)) begin
         do_push = 1'b1;
         w = pack_word();
         m_bytes.delete();
         m_idle = 0;
      end
      if (m_bytes.size() == 0) m_idle = 0;
      if (do_pop) void'(m_fifo.pop_front());
      if (do_push) begin
         if (sz < DEPTH || do_pop) m_fifo.push_back(w);
         else m_ovf = 1'b1;
      end
      if (clr_ovf && !(do_push && sz == DEPTH && !do_pop)) m_ovf = 1'b0;
   endtask

   task automatic compare_all();
      logic [34:0] h;
      h = (m_fifo.size() > 0) ? m_fifo[0] : 35'd0;
      check("word_valid", 35'(word_valid), 35'(m_fifo.size() > 0));
      check("word_data",  35'(word_data),  35'(h[31:0]));
      check("word_bytes", 35'(word_bytes), 35'(h[34:32]));
      check("level",      35'(level),      35'(m_fifo.size()));
      check("overflow",   35'(overflow),   35'(m_ovf));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic f,
                       input logic r, input logic c);
      rx_valid   = v;
      rx_data    = d;
      flush      = f;
      word_ready = r;
      clr_ovf    = c;
      @(posedge sys_clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, r, 1'b0);
   endtask

   task automatic full_word(input logic [31:0] w, input logic r_last, input logic c_last);
      for (int i = 0; i < 3; i++) step(1'b1, w[31-8*i -: 8], 1'b0, 1'b0, 1'b0);
      step(1'b1, w[7:0], 1'b0, r_last, c_last);
   endtask

   logic [31:0] last_seen;

   initial begin
      #2;
      check("rst_valid", 35'(word_valid), 35'd0);
      check("rst_level", 35'(level), 35'd0);
      check("rst_ovf",   35'(overflow), 35'd0);
      #10 sys_nrst = 1'b1;
      idle(2, 1'b1);

      // Full word
      step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b1);
      step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
      check("full_data",  35'(word_data), 35'h11223344);
      check("full_bytes", 35'(word_bytes), 35'd4);
      idle(1, 1'b1);
      check("full_popped", 35'(word_valid), 35'd0);

      // Timeout
      step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      idle(TIMEOUT - 1, 1'b0);
      check("tmo_early", 35'(level), 35'd0);
      idle(1, 1'b0);
      check("tmo_data",  35'(word_data), 35'hAABB0000);
      check("tmo_bytes", 35'(word_bytes), 35'd2);
      idle(1, 1'b1);

      // Flush
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("flush_empty", 35'(level), 35'd0);
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
      check("flush_data",  35'(word_data), 35'h01020300);
      check("flush_bytes", 35'(word_bytes), 35'd3);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("flush_cnt0", 35'(level), 35'd1);
      idle(1, 1'b1);

      // Overflow
      for (int n = 1; n <= 17; n++) full_word({8'(n), 24'hA55A0F}, 1'b0, 1'b0);
      check("ovf_level", 35'(level), 35'd16);
      check("ovf_set",   35'(overflow), 35'd1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_clr", 35'(overflow), 35'd0);
      full_word(32'hFFFFFFFF, 1'b0, 1'b1);
      check("ovf_set_wins", 35'(overflow), 35'd1);
      for (int n = 1; n <= 16; n++) begin
         check("ovf_order", 35'(word_data[31:24]), 35'(n));
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Full with simultaneous pop
      for (int n = 1; n <= 16; n++) full_word({8'(n), 24'h123456}, 1'b0, 1'b0);
      full_word(32'hCAFEF00D, 1'b1, 1'b0);
      check("fpop_ovf",   35'(overflow), 35'd0);
      check("fpop_level", 35'(level), 35'd16);
      last_seen = '0;
      for (int n = 0; n < 16; n++) begin
         last_seen = word_data;
         step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
      check("fpop_last", 35'(last_seen), 35'hCAFEF00D);

      // Randomized traffic in phases of differing byte density and back-pressure
      for (int ph = 0; ph < 20; ph++) begin
         int pv, pr;
         case ($urandom_range(0, 2))
            0: pv = 60;
            1: pv = 2;
            default: pv = 25;
         endcase
         pr = ($urandom_range(0, 3) == 0) ? 3 : 50;
         for (int i = 0; i < 200; i++)
            step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < pr, $urandom_range(0, 99) < 2);
      end

      // Reset mid-word
      idle(20, 1'b1);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      full_word(32'h01234567, 1'b0, 1'b0);
      rx_valid = 1'b0;
      #3 sys_nrst = 1'b0;
      model_reset();
      #1;
      check("mrst_valid", 35'(word_valid), 35'd0);
      check("mrst_data",  35'(word_data), 35'd0);
      check("mrst_bytes", 35'(word_bytes), 35'd0);
      check("mrst_level", 35'(level), 35'd0);
      #2 sys_nrst = 1'b1;
      full_word(32'hDEADBEEF, 1'b0, 1'b0);
      check("mrst_word",  35'(word_data), 35'hDEADBEEF);
      check("mrst_count", 35'(level), 35'd1);
      idle(TIMEOUT + 5, 1'b1);
      check("mrst_only", 35'(level), 35'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
